gates2_checker: RTL and testbench
=================================

GATES2_CHECKER -- requirements
Module: gates2_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: begin a check run.
REQ-005 SHALL have port stop, input, 1: end the run and request a verdict.
REQ-006 SHALL have port sample_en, input, 1: a, b and z are valid this cycle.
REQ-007 SHALL have ports a and b, each input, 1: stimulus applied to the gates2 unit.
REQ-008 SHALL have port z, input, 6: gates2 response, mapped z[5]=AND, z[4]=NAND, z[3]=OR, z[2]=NOR, z[1]=XOR, z[0]=XNOR.
REQ-009 SHALL have port mismatch, output, 1: one-cycle pulse when a compared vector is wrong.
REQ-010 SHALL have port err_cnt, output, CNT_W: count of mismatches.
REQ-011 SHALL have port cov, output, 4: input combinations seen; bit index {a,b}.
REQ-012 SHALL have ports done, pass and fail, each output, 1: verdict flags.
REQ-013 SHALL have port first_err, output, 8: {a,b,z} of the first mismatching vector.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, PASS and FAIL.
REQ-015 SHALL move IDLE/PASS/FAIL->RUN on start=1, clearing err_cnt, cov, first_err and the pipeline in that same edge.
REQ-016 SHALL ignore start while in RUN or DRAIN.
REQ-017 SHALL, in RUN, register {a,b,z} on each edge where sample_en=1 (stage 1), with the valid flag set.
REQ-018 SHALL, on the next edge, compare the stage-1 z with the expected 6-bit value computed from the stage-1 a and b, and register the results: mismatch, err_cnt, cov[{a,b}]=1.
REQ-019 SHALL make results visible 2 edges after the sampling edge.
REQ-020 SHALL allow back-to-back samples at full throughput.
REQ-021 SHALL ignore sample_en outside RUN; a sample_en=1 in the same cycle as stop SHALL still be accepted.
REQ-022 SHALL move RUN->DRAIN on stop=1.
REQ-023 SHALL leave DRAIN after exactly one cycle, once the final stage-1 entry is compared: PASS if err_cnt==0 and cov==4'hF, else FAIL.
REQ-024 SHALL saturate err_cnt at 2^CNT_W-1, with no wrap-around.
REQ-025 SHALL drive done=1 in PASS or FAIL; pass=1 only in PASS; fail=1 only in FAIL; all three held until start or rst.

Reset
REQ-026 SHALL, on rst=1, force IDLE, clear the stage-1 valid flag, and set mismatch=0, err_cnt=0, cov=0, done=0, pass=0, fail=0, first_err=0.
REQ-027 SHALL give rst priority over start, stop and sample_en in the same cycle; an in-flight sample SHALL be discarded.

Configuration
REQ-028 SHALL, with macro GATES2_CHECKER_FIRSTERR_EN defined, load first_err on the first mismatch after start and hold it for the rest of the run.
REQ-029 SHALL, without GATES2_CHECKER_FIRSTERR_EN, tie first_err to 8'h00 and synthesize no capture register.

Verification
REQ-030 SHALL cover: start; vectors (a,b,z)=(0,0,010101), (0,1,011010), (1,0,011010), (1,1,101001); stop -> PASS, err_cnt=0, cov=4'hF, mismatch never asserted.
REQ-031 SHALL cover: start; (1,1,101000); stop -> mismatch pulse 2 edges after the sample, err_cnt=1, first_err=8'hE8 (macro on) or 8'h00 (macro off), FAIL.
REQ-032 SHALL cover: start; correct vectors for 00, 01 and 10 only; stop -> FAIL, cov=4'b0111, err_cnt=0.
REQ-033 SHALL cover: CNT_W=8, 300 consecutive wrong vectors -> err_cnt=255 and held there.
REQ-034 SHALL cover: in RUN, wrong vector sampled, rst=1 on the next cycle -> err_cnt=0, mismatch=0, state IDLE.
REQ-035 SHALL cover: sample_en with wrong vectors in IDLE and in PASS -> err_cnt and cov unchanged.

Source files
------------

// File: rtl/gates2_checker.sv
// Self-checker for a 2-input gates2 unit (AND/NAND/OR/NOR/XOR/XNOR); optional first_err capture via GATES2_CHECKER_FIRSTERR_EN.
// Latency: a sample's mismatch/err_cnt/cov result registers on the second edge after it is presented; verdict one edge after stop.
// Backpressure: none; sample_en is accepted every cycle in RUN (including the stop cycle) at full throughput.
module gates2_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic [5:0]       z,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [7:0]       first_err
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_t;

  typedef struct packed {
    logic       a;
    logic       b;
    logic [5:0] z;
  } vec_t;

  state_t           state;
  vec_t             s1_dat;
  logic             s1_vld;
  logic [5:0]       exp_z;
  logic             cmp_bad;
  logic             start_acc;
  logic             smp_acc;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]       cov_nxt;
  logic             verdict_ok;

  function automatic logic [5:0] gates2_ref(input logic ia, input logic ib);
    return {ia & ib, ~(ia & ib), ia | ib, ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
  endfunction

  always_comb begin
    start_acc = start && (state == IDLE || state == PASS || state == FAIL);
    smp_acc   = sample_en && (state == RUN);
    exp_z     = gates2_ref(s1_dat.a, s1_dat.b);
    cmp_bad   = s1_vld && (s1_dat.z != exp_z);
    err_nxt   = err_cnt;
    if (cmp_bad && (err_cnt != {CNT_W{1'b1}}))
      err_nxt = err_cnt + CNT_W'(1);
    cov_nxt = cov;
    if (s1_vld)
      cov_nxt = cov | (4'b0001 << {s1_dat.a, s1_dat.b});
    // DRAIN judges on the values that include the last in-flight comparison.
    verdict_ok = (err_nxt == '0) && (cov_nxt == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s1_vld   <= 1'b0;
      s1_dat   <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      cov      <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      s1_vld   <= smp_acc;
      if (smp_acc)
        s1_dat <= '{a: a, b: b, z: z};
      mismatch <= cmp_bad;
      err_cnt  <= err_nxt;
      cov      <= cov_nxt;
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            state    <= RUN;
            s1_vld   <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            cov      <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
          end
        end
        RUN: begin
          if (stop)
            state <= DRAIN;
        end
        DRAIN: begin
          done  <= 1'b1;
          pass  <= verdict_ok;
          fail  <= !verdict_ok;
          state <= verdict_ok ? PASS : FAIL;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATES2_CHECKER_FIRSTERR_EN
  logic [7:0] first_err_q;

  // err_cnt is still zero only until the first mismatch of the run lands.
  always_ff @(posedge clk) begin
    if (rst)
      first_err_q <= 8'h00;
    else if (start_acc)
      first_err_q <= 8'h00;
    else if (cmp_bad && (err_cnt == '0))
      first_err_q <= s1_dat;
  end

  assign first_err = first_err_q;
`else
  assign first_err = 8'h00;
`endif

endmodule

// File: tb/tb_gates2_checker.sv
// Directed bench for gates2_checker: stimulus pushes expectations into queues, a monitor pops and compares.
module tb_gates2_checker;

  logic       clk = 1'b0;
  logic       rst, start, stop, sample_en, a, b;
  logic [5:0] z;
  logic       mismatch, done, pass, fail;
  logic [7:0] err_cnt, first_err;
  logic [3:0] cov;

  logic tag = 1'b0;
  logic t1 = 1'b0;
  logic t2 = 1'b0;
  bit   done_seen = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       mm;
    logic [7:0] err;
    logic [3:0] cov;
  } smp_exp_t;

  typedef struct {
    logic       ok;
    logic [7:0] err;
    logic [3:0] cov;
    logic [7:0] first;
  } vrd_exp_t;

  smp_exp_t smp_q[$];
  vrd_exp_t vrd_q[$];

  logic [7:0] m_err;
  logic [3:0] m_cov;
  logic [7:0] m_first;
  bit         m_fseen;

  gates2_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
    .a(a), .b(b), .z(z), .mismatch(mismatch), .err_cnt(err_cnt), .cov(cov),
    .done(done), .pass(pass), .fail(fail), .first_err(first_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Hand-written truth table, {AND,NAND,OR,NOR,XOR,XNOR}.
  function automatic logic [5:0] gold(input logic [1:0] ab);
    case (ab)
      2'b00:   return 6'b010101;
      2'b01:   return 6'b011010;
      2'b10:   return 6'b011010;
      default: return 6'b101001;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_verdict();
    vrd_exp_t v;
    v.ok  = (m_err == 8'd0) && (m_cov == 4'hF);
    v.err = m_err;
    v.cov = m_cov;
`ifdef GATES2_CHECKER_FIRSTERR_EN
    v.first = m_first;
`else
    v.first = 8'h00;
`endif
    vrd_q.push_back(v);
  endtask

  task automatic smp(input logic ia, input logic ib, input logic [5:0] iz, input bit acc, input bit with_stop);
    smp_exp_t e;
    @(negedge clk);
    start = 1'b0; stop = with_stop; sample_en = 1'b1;
    a = ia; b = ib; z = iz; tag = acc;
    if (acc) begin
      e.mm = (iz != gold({ia, ib}));
      if (e.mm && m_err != 8'd255) m_err = m_err + 8'd1;
      if (e.mm && !m_fseen) begin
        m_first = {ia, ib, iz};
        m_fseen = 1'b1;
      end
      m_cov[{ia, ib}] = 1'b1;
      e.err = m_err;
      e.cov = m_cov;
      smp_q.push_back(e);
    end
    if (with_stop) push_verdict();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; sample_en = 1'b0; tag = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; stop = 1'b0; sample_en = 1'b0; tag = 1'b0;
    m_err = 8'd0; m_cov = 4'd0; m_first = 8'd0; m_fseen = 1'b0;
  endtask

  task automatic stop_only();
    @(negedge clk);
    start = 1'b0; stop = 1'b1; sample_en = 1'b0; tag = 1'b0;
    push_verdict();
  endtask

  task automatic wait_verdict();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1);
      seen = done;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      if (vrd_q.size() > 0) void'(vrd_q.pop_front());
    end
    idle(1);
  endtask

  always @(posedge clk) begin
    t1 <= tag;
    t2 <= t1;
  end

  always @(negedge clk) begin
    smp_exp_t e;
    vrd_exp_t v;
    if (t2) begin
      if (smp_q.size() == 0) begin
        check("smp_q_underflow", 32'd1, 32'd0);
      end else begin
        e = smp_q.pop_front();
        check("mismatch", 32'(mismatch), 32'(e.mm));
        check("err_cnt", 32'(err_cnt), 32'(e.err));
        check("cov", 32'(cov), 32'(e.cov));
      end
    end else if (mismatch) begin
      check("stray_mismatch", 32'(mismatch), 32'd0);
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      if (vrd_q.size() == 0) begin
        check("vrd_q_underflow", 32'd1, 32'd0);
      end else begin
        v = vrd_q.pop_front();
        check("verdict_pass", 32'(pass), 32'(v.ok));
        check("verdict_fail", 32'(fail), 32'(!v.ok));
        check("verdict_err", 32'(err_cnt), 32'(v.err));
        check("verdict_cov", 32'(cov), 32'(v.cov));
        check("verdict_first", 32'(first_err), 32'(v.first));
      end
    end else if (!done) begin
      done_seen = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
    a = 1'b0; b = 1'b0; z = 6'd0;
    m_err = 8'd0; m_cov = 4'd0; m_first = 8'd0; m_fseen = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_cov", 32'(cov), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_first_err", 32'(first_err), 32'd0);

    // Wrong samples in IDLE must be ignored.
    smp(1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    smp(1'b0, 1'b1, 6'b111111, 1'b0, 1'b0);
    idle(3);
    check("idle_err_cnt", 32'(err_cnt), 32'd0);
    check("idle_cov", 32'(cov), 32'd0);

    // All four correct vectors, the last one in the stop cycle.
    do_start();
    smp(1'b0, 1'b0, 6'b010101, 1'b1, 1'b0);
    smp(1'b0, 1'b1, 6'b011010, 1'b1, 1'b0);
    smp(1'b1, 1'b0, 6'b011010, 1'b1, 1'b0);
    smp(1'b1, 1'b1, 6'b101001, 1'b1, 1'b1);
    wait_verdict();

    // Wrong samples in PASS must be ignored.
    smp(1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 6'b000000, 1'b0, 1'b0);
    idle(3);
    check("pass_hold_err_cnt", 32'(err_cnt), 32'd0);
    check("pass_hold_cov", 32'(cov), 32'hF);
    check("pass_hold_pass", 32'(pass), 32'd1);

    // Single wrong vector.
    do_start();
    smp(1'b1, 1'b1, 6'b101000, 1'b1, 1'b0);
    stop_only();
    wait_verdict();

    // Incomplete coverage.
    do_start();
    smp(1'b0, 1'b0, 6'b010101, 1'b1, 1'b0);
    smp(1'b0, 1'b1, 6'b011010, 1'b1, 1'b0);
    smp(1'b1, 1'b0, 6'b011010, 1'b1, 1'b0);
    stop_only();
    wait_verdict();

    // 300 back-to-back wrong vectors saturate the counter.
    do_start();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] ab;
      ab = 2'(i % 4);
      smp(ab[1], ab[0], gold(ab) ^ 6'b000001, 1'b1, 1'b0);
    end
    stop_only();
    wait_verdict();

    // Reset discards an in-flight wrong sample.
    do_start();
    smp(1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; sample_en = 1'b0; tag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_run_mismatch", 32'(mismatch), 32'd0);
    check("rst_run_done", 32'(done), 32'd0);
    smp(1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
    idle(3);
    check("rst_idle_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_idle_cov", 32'(cov), 32'd0);

    idle(2);
    check("smp_q_empty", 32'(smp_q.size()), 32'd0);
    check("vrd_q_empty", 32'(vrd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
